kbd_mem_arbiter: RTL and testbench
==================================

# kbd_mem_arbiter

Arbiter and sequencer that shares the single data-memory port between the MIPS core and the PS/2 keyboard path. Keyboard make-codes are captured, queued, and written into the calculator mailbox words (operand 1, operand 2, operator, plus two valid flags) as ordinary memory writes. The CPU keeps priority, but the keyboard path is never starved. The block sits between the core/keyboard decoder and `Memory`, driving its `MemRead`/`MemWrite`/`Address`/`WriteData`.

## Interface
- `FIFO_DEPTH`, 4: keyboard make-code queue depth (power of two, ≥2).
- `NUM1_ADDR`, 33: word address of operand 1.
- `NUM2_ADDR`, 34: word address of operand 2.
- `OP_ADDR`, 35: word address of the operator code.
- `FLAG1_ADDR`, 36: operand-1 valid flag.
- `FLAG2_ADDR`, 37: operand-2 valid flag.
- `MAX_WAIT`, 3: cycles a pending keyboard write may be deferred before it is forced.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `CpuMemRead`  in  1  core read request.
- `CpuMemWrite`  in  1  core write request.
- `CpuAddress`  in  32  core word address.
- `CpuWriteData`  in  32  core write data.
- `newchar`  in  1  keyboard decoder strobe (level; may stay high several cycles).
- `char`  in  16  last two scancode bytes; `[15:8]` prefix, `[7:0]` code.
- `MemRead`  out  1  to memory.
- `MemWrite`  out  1  to memory.
- `Address`  out  32  to memory.
- `WriteData`  out  32  to memory.
- `CpuStall`  out  1  core request not serviced this cycle; core must hold request.
- `KbdOverflow`  out  1  sticky: a make-code was dropped on full queue.
- `KbdField`  out  2  next field to be filled (0 NUM1, 1 NUM2, 2 OP).

## Operation
- Capture: rising edge of `newchar` (registered previous value) is one event. If `char[15:8] == 8'hF0` (break code), the event is ignored. Otherwise, `char[7:0]` is pushed into the queue.
- Queue full on push and no pop in the same cycle: drop the code and set `KbdOverflow`. Simultaneous push and pop when full: both are accepted.
- Writer FSM: `K_IDLE` → `K_DATA` when the queue is non-empty.
  - `K_DATA` presents a write of `{24'b0, code}` to the address for the current field.
  - On grant: field NUM1/NUM2 → `K_FLAG`; field OP → pop, field becomes NUM1, next state `K_IDLE`/`K_DATA`.
  - `K_FLAG` presents a write of 32'd1 to `FLAG1_ADDR`/`FLAG2_ADDR`. On grant: pop, advance field (NUM1→NUM2, NUM2→OP), go to `K_IDLE`/`K_DATA`.
  - Field 3 is unreachable; if it is ever entered, it is treated as NUM1.
- Arbitration (combinational, from registered state):
  - CPU request (`CpuMemRead | CpuMemWrite`) wins unless the wait counter equals `MAX_WAIT`.
  - In that case the keyboard is granted and `CpuStall = 1`.
  - If there is no CPU request, a pending keyboard write is granted.
- Wait counter: increments each cycle a keyboard write is pending and not granted. It clears on keyboard grant and saturates at `MAX_WAIT`.
- CPU grant passes core signals through. If read and write are both asserted, read wins and `MemWrite = 0`.
- Nothing granted: all memory outputs are 0.

## Timing
- Reset (`rst_n` low, asynchronous): queue empty, FSM `K_IDLE`, field NUM1, wait counter 0, `KbdOverflow = 0`, edge register 0.
- Output reset values: `MemRead = 0`, `MemWrite = 0`, `Address = 0`, `WriteData = 0`, `CpuStall = 0`, `KbdOverflow = 0`, `KbdField = 0`.
- Reset mid-sequence discards pending data/flag writes and queued codes.
- CPU path: zero added latency, combinational pass-through when granted.
- Keyboard path: with an idle CPU, the first memory write occurs 2 cycles after the `newchar` rising edge (capture cycle, then `K_DATA`).
  - The flag write follows on the next cycle.
  - Worst case with the CPU busy: `MAX_WAIT + 1` cycles per write.
- `CpuStall` is high for exactly one cycle per forced keyboard grant.

## Structure
- Package `kbd_arb_pkg`: writer state enum (`K_IDLE`, `K_DATA`, `K_FLAG`), field enum (`F_NUM1`, `F_NUM2`, `F_OP`), `BREAK_PREFIX = 8'hF0`.
- Sub-module `kbd_fifo`: synchronous FIFO of 8-bit codes with full/empty flags and simultaneous push/pop.

## Test plan
- Idle CPU; make-codes 0x16, 0x1E, 0x79 → writes M[33]=0x16, M[36]=1, M[34]=0x1E, M[37]=1, M[35]=0x79; `KbdField` returns to 0.
- `newchar` held high 5 cycles with char=0x0016 → exactly one push. Then char=0xF016 with a new edge → no write.
- CPU issues back-to-back writes for 10 cycles while a code is pending → keyboard write is forced on the 4th cycle with `CpuStall = 1` for that cycle only; CPU data is unchanged.
- 5 codes pushed with CPU continuously stalling the writer → the 5th is dropped, `KbdOverflow = 1` (sticky), and the first 4 are written in order.
- `rst_n` pulsed low between the NUM1 data and flag writes → no M[36] write; next code targets M[33].
- `CpuMemRead = 1` and `CpuMemWrite = 1` together at address 7 → `MemRead = 1`, `MemWrite = 0`, `Address = 7`.

Source files
------------

// File: rtl/kbd_arb_pkg.sv
// Shared types and constants for the keyboard/CPU memory-port arbiter.
package kbd_arb_pkg;

  typedef enum logic [1:0] {
    K_IDLE = 2'd0,
    K_DATA = 2'd1,
    K_FLAG = 2'd2
  } kstate_e;

  typedef enum logic [1:0] {
    F_NUM1 = 2'd0,
    F_NUM2 = 2'd1,
    F_OP   = 2'd2
  } field_e;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

endpackage

// File: rtl/kbd_mem_arbiter_fifo.sv
// Synchronous FIFO of 8-bit make-codes; a push into a full queue is accepted
// only when a pop happens in the same cycle.
module kbd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push_s;
  logic        do_pop_s;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign data_o    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/kbd_mem_arbiter.sv
// Shares the data-memory port between the core and the keyboard mailbox
// writer; the core has priority but a deferred keyboard write is forced.
module kbd_mem_arbiter
  import kbd_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM1_ADDR  = 33,
  parameter int NUM2_ADDR  = 34,
  parameter int OP_ADDR    = 35,
  parameter int FLAG1_ADDR = 36,
  parameter int FLAG2_ADDR = 37,
  parameter int MAX_WAIT   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CpuMemRead,
  input  logic        CpuMemWrite,
  input  logic [31:0] CpuAddress,
  input  logic [31:0] CpuWriteData,
  input  logic        newchar,
  input  logic [15:0] char,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  output logic        CpuStall,
  output logic        KbdOverflow,
  output logic [1:0]  KbdField
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  kstate_e       state_q;
  field_e        field_q;
  logic [WW-1:0] wait_q;
  logic          newchar_q;
  logic          overflow_q;

  logic          push_s;
  logic          pop_s;
  logic          more_s;
  logic [7:0]    code_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [AW:0]   fifo_count_s;
  logic          cpu_req_s;
  logic          kbd_pending_s;
  logic          kbd_grant_s;
  logic [31:0]   kbd_addr_s;

  kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .data_i  (char[7:0]),
    .pop_i   (pop_s),
    .data_o  (code_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign push_s        = newchar && !newchar_q && (char[15:8] != BREAK_PREFIX);
  assign cpu_req_s     = CpuMemRead || CpuMemWrite;
  assign kbd_pending_s = (state_q == K_DATA) || (state_q == K_FLAG);
  assign kbd_grant_s   = kbd_pending_s && (!cpu_req_s || (wait_q == WAIT_MAX));
  assign pop_s         = kbd_grant_s &&
                         ((state_q == K_FLAG) || (field_q == F_OP));
  // Something is still queued after this cycle's pop if more than one entry
  // is held or a new code arrives now.
  assign more_s        = (fifo_count_s > CNT_ONE) || push_s;
  assign KbdOverflow   = overflow_q;
  assign KbdField      = field_q;

  always_comb begin
    kbd_addr_s = 32'(NUM1_ADDR);
    case (field_q)
      F_NUM2:  kbd_addr_s = (state_q == K_FLAG) ? 32'(FLAG2_ADDR) : 32'(NUM2_ADDR);
      F_OP:    kbd_addr_s = 32'(OP_ADDR);
      default: kbd_addr_s = (state_q == K_FLAG) ? 32'(FLAG1_ADDR) : 32'(NUM1_ADDR);
    endcase
  end

  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = 32'd0;
    WriteData = 32'd0;
    CpuStall  = cpu_req_s && kbd_grant_s;
    if (kbd_grant_s) begin
      MemWrite  = 1'b1;
      Address   = kbd_addr_s;
      WriteData = (state_q == K_DATA) ? {24'd0, code_s} : 32'd1;
    end else if (cpu_req_s) begin
      MemRead   = CpuMemRead;
      MemWrite  = CpuMemWrite && !CpuMemRead;
      Address   = CpuAddress;
      WriteData = CpuWriteData;
    end else begin
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= K_IDLE;
      field_q    <= F_NUM1;
      wait_q     <= '0;
      newchar_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      newchar_q <= newchar;
      if (push_s && fifo_full_s && !pop_s) begin
        overflow_q <= 1'b1;
      end
      if (kbd_grant_s) begin
        wait_q <= '0;
      end else if (kbd_pending_s && (wait_q != WAIT_MAX)) begin
        wait_q <= wait_q + WW'(1);
      end
      // An out-of-range field value behaves as NUM1 throughout.
      case (state_q)
        K_IDLE: begin
          if (!fifo_empty_s) begin
            state_q <= K_DATA;
          end
        end
        K_DATA: begin
          if (kbd_grant_s) begin
            if (field_q == F_OP) begin
              field_q <= F_NUM1;
              state_q <= more_s ? K_DATA : K_IDLE;
            end else begin
              state_q <= K_FLAG;
            end
          end
        end
        K_FLAG: begin
          if (kbd_grant_s) begin
            field_q <= (field_q == F_NUM2) ? F_OP : F_NUM2;
            state_q <= more_s ? K_DATA : K_IDLE;
          end
        end
        default: state_q <= K_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_mem_arbiter.sv
// Self-checking bench: mailbox writes are compared with a queue model derived
// from the field rotation; CPU pass-through and stall behaviour checked inline.
module tb_kbd_mem_arbiter;

  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        newchar;
  logic [15:0] chr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic        cpu_stall, kbd_ovf;
  logic [1:0]  kbd_field;

  int checks = 0;
  int failures = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  int model_field = 0;

  always #5 clk = ~clk;

  kbd_mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .CpuMemRead(cpu_rd), .CpuMemWrite(cpu_wr),
    .CpuAddress(cpu_addr), .CpuWriteData(cpu_wdata),
    .newchar(newchar), .char(chr),
    .MemRead(mem_rd), .MemWrite(mem_wr),
    .Address(mem_addr), .WriteData(mem_wdata),
    .CpuStall(cpu_stall), .KbdOverflow(kbd_ovf), .KbdField(kbd_field)
  );

  // Record every mailbox write the memory would commit at the next edge.
  always @(negedge clk) begin
    if (mem_wr && mem_addr >= 32'd33 && mem_addr <= 32'd37)
      obs_q.push_back({mem_addr, mem_wdata});
  end

  task automatic model_code(input logic [7:0] code);
    case (model_field)
      0: begin exp_q.push_back({32'd33, 24'd0, code}); exp_q.push_back({32'd36, 32'd1}); end
      1: begin exp_q.push_back({32'd34, 24'd0, code}); exp_q.push_back({32'd37, 32'd1}); end
      default: exp_q.push_back({32'd35, 24'd0, code});
    endcase
    model_field = (model_field + 1) % 3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    newchar = 1'b0; chr = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    obs_q.delete(); exp_q.delete(); model_field = 0;
  endtask

  task automatic press(input logic [15:0] c, input int hold);
    chr = c; newchar = 1'b1;
    repeat (hold) tick();
    newchar = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({mem_rd, mem_wr, mem_addr, mem_wdata, cpu_stall, kbd_ovf, kbd_field} !== 69'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rd=%0b wr=%0b addr=%0h wd=%0h stall=%0b ovf=%0b field=%0d required all 0",
               mem_rd, mem_wr, mem_addr, mem_wdata, cpu_stall, kbd_ovf, kbd_field);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({mem_rd, mem_wr, mem_addr, mem_wdata, cpu_stall, kbd_ovf, kbd_field} !== 69'd0) begin
      failures++;
      $display("FAIL idle_outputs: got rd=%0b wr=%0b addr=%0h wd=%0h stall=%0b ovf=%0b field=%0d required all 0",
               mem_rd, mem_wr, mem_addr, mem_wdata, cpu_stall, kbd_ovf, kbd_field);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    model_code(8'h16);
    chr = 16'h0016; newchar = 1'b1;
    tick();
    newchar = 1'b0;
    checks++;
    if (mem_wr !== 1'b0) begin
      failures++; $display("FAIL latency_early: got MemWrite=%0b required 0", mem_wr);
    end
    tick();
    checks++;
    if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'd33, 32'h16}) begin
      failures++; $display("FAIL latency_data: got wr=%0b addr=%0d data=%0h required wr=1 addr=33 data=16", mem_wr, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'd36, 32'd1}) begin
      failures++; $display("FAIL latency_flag: got wr=%0b addr=%0d data=%0h required wr=1 addr=36 data=1", mem_wr, mem_addr, mem_wdata);
    end
    repeat (3) tick();
    press(16'h001E, 1); model_code(8'h1E);
    repeat (6) tick();
    press(16'h0079, 1); model_code(8'h79);
    repeat (10) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL seq_count: got %0d writes required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL seq_write[%0d]: got %0h required %0h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (kbd_field !== 2'(model_field)) begin
      failures++; $display("FAIL seq_field: got %0d required %0d", kbd_field, model_field);
    end
  endtask

  task automatic test_hold_and_break();
    do_reset();
    press(16'h0016, 5); model_code(8'h16);
    repeat (12) tick();
    press(16'hF016, 1);
    repeat (12) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL hold_count: got %0d writes required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL hold_write[%0d]: got %0h required %0h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (kbd_field !== 2'(model_field)) begin
      failures++; $display("FAIL hold_field: got %0d required %0d", kbd_field, model_field);
    end
  endtask

  task automatic test_forced_grant();
    int  idx;
    logic exp_stall;
    do_reset();
    model_code(8'h2A);
    chr = 16'h002A; newchar = 1'b1;
    tick();
    newchar = 1'b0;
    tick();
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (idx < 10) begin
        cpu_wr = 1'b1; cpu_addr = 32'(idx + 1); cpu_wdata = 32'hC0DE_0000 + 32'(idx);
      end else begin
        cpu_wr = 1'b0;
      end
      #1;
      exp_stall = (cyc == MAX_WAIT) || (cyc == 2 * MAX_WAIT + 1);
      checks++;
      if (cpu_stall !== exp_stall) begin
        failures++; $display("FAIL forced_stall[%0d]: got %0b required %0b", cyc, cpu_stall, exp_stall);
      end
      if (!exp_stall && idx < 10) begin
        checks++;
        if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'(idx + 1), 32'hC0DE_0000 + 32'(idx)}) begin
          failures++; $display("FAIL forced_cpu[%0d]: got addr=%0d data=%0h required addr=%0d data=%0h",
                               cyc, mem_addr, mem_wdata, idx + 1, 32'hC0DE_0000 + 32'(idx));
        end
      end
      if (!cpu_stall) idx++;
      tick();
    end
    cpu_wr = 1'b0;
    repeat (5) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL forced_count: got %0d writes required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL forced_write[%0d]: got %0h required %0h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes[0] = 8'h15; codes[1] = 8'h24; codes[2] = 8'h2D; codes[3] = 8'h3C; codes[4] = 8'h4B;
    do_reset();
    cpu_wr = 1'b1; cpu_addr = 32'd2; cpu_wdata = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) model_code(codes[k]);
      press({8'h00, codes[k]}, 1);
    end
    repeat (3) tick();
    checks++;
    if (kbd_ovf !== 1'b1) begin
      failures++; $display("FAIL overflow_set: got %0b required 1", kbd_ovf);
    end
    repeat (30) tick();
    cpu_wr = 1'b0;
    repeat (10) tick();
    checks++;
    if (kbd_ovf !== 1'b1) begin
      failures++; $display("FAIL overflow_sticky: got %0b required 1", kbd_ovf);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL overflow_count: got %0d writes required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL overflow_write[%0d]: got %0h required %0h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    chr = 16'h0016; newchar = 1'b1;
    tick();
    newchar = 1'b0;
    tick();
    checks++;
    if ({mem_wr, mem_addr} !== {1'b1, 32'd33}) begin
      failures++; $display("FAIL midrst_data: got wr=%0b addr=%0d required wr=1 addr=33", mem_wr, mem_addr);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_wr, kbd_field} !== 3'd0) begin
      failures++; $display("FAIL midrst_outputs: got wr=%0b field=%0d required 0 0", mem_wr, kbd_field);
    end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (obs_q.size() != 1) begin
      failures++; $display("FAIL midrst_count: got %0d writes required 1", obs_q.size());
    end
    obs_q.delete(); exp_q.delete(); model_field = 0;
    press(16'h001E, 1); model_code(8'h1E);
    repeat (8) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL midrst_next_count: got %0d writes required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL midrst_write[%0d]: got %0h required %0h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_read_write_conflict();
    do_reset();
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'd7; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({mem_rd, mem_wr, mem_addr, cpu_stall} !== {1'b1, 1'b0, 32'd7, 1'b0}) begin
      failures++; $display("FAIL rw_conflict: got rd=%0b wr=%0b addr=%0d stall=%0b required rd=1 wr=0 addr=7 stall=0",
                           mem_rd, mem_wr, mem_addr, cpu_stall);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    logic       hold;
    int         stall_run;
    logic [7:0] code, pre;
    do_reset();
    hold = 1'b0; stall_run = 0;
    for (int k = 0; k < 8; k++) begin
      code = 8'($urandom_range(1, 255));
      case ($urandom_range(0, 2))
        0: pre = 8'h00;
        1: pre = 8'hE0;
        default: pre = 8'hF0;
      endcase
      if (pre != 8'hF0) model_code(code);
      for (int c = 0; c < 24; c++) begin
        newchar = (c == 0);
        chr = {pre, code};
        if (!hold) begin
          if ($urandom_range(0, 9) < 6) begin
            case ($urandom_range(0, 2))
              0: {cpu_rd, cpu_wr} = 2'b10;
              1: {cpu_rd, cpu_wr} = 2'b01;
              default: {cpu_rd, cpu_wr} = 2'b11;
            endcase
            cpu_addr = 32'($urandom_range(0, 31)); cpu_wdata = $urandom();
          end else begin
            {cpu_rd, cpu_wr} = 2'b00;
          end
        end
        #1;
        if (cpu_stall) stall_run++; else stall_run = 0;
        checks++;
        if (stall_run > 1) begin
          failures++; $display("FAIL rnd_stall_run: got %0d consecutive stall cycles required at most 1", stall_run);
        end
        if (cpu_rd || cpu_wr) begin
          if (!cpu_stall) begin
            checks++;
            if ({mem_rd, mem_wr, mem_addr, mem_wdata} !== {cpu_rd, cpu_wr && !cpu_rd, cpu_addr, cpu_wdata}) begin
              failures++; $display("FAIL rnd_passthru: got rd=%0b wr=%0b addr=%0d data=%0h required rd=%0b wr=%0b addr=%0d data=%0h",
                                   mem_rd, mem_wr, mem_addr, mem_wdata, cpu_rd, cpu_wr && !cpu_rd, cpu_addr, cpu_wdata);
            end
          end
        end else begin
          checks++;
          if (cpu_stall !== 1'b0) begin
            failures++; $display("FAIL rnd_idle_stall: got %0b required 0", cpu_stall);
          end
        end
        hold = cpu_stall;
        tick();
      end
    end
    idle_inputs();
    repeat (20) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rnd_count: got %0d writes required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rnd_write[%0d]: got %0h required %0h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (kbd_field !== 2'(model_field)) begin
      failures++; $display("FAIL rnd_field: got %0d required %0d", kbd_field, model_field);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_hold_and_break();
    test_forced_grant();
    test_overflow();
    test_reset_mid();
    test_read_write_conflict();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
